alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 35 +++
 rtl/alu_mc_muldiv.sv | 119 +++++++++++
 rtl/alu_mc.sv | 159 +++++++++++++++
 tb/tb_alu_mc.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// alu_mc shared definitions: op codes, FSM state type, default width.
// Optional multiply/divide support is enabled by ALU_MC_MULDIV_EN.
package alu_mc_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b01000;
  localparam logic [4:0] OP_SLL   = 5'b00001;
  localparam logic [4:0] OP_SLT   = 5'b00010;
  localparam logic [4:0] OP_SLTU  = 5'b01010;
  localparam logic [4:0] OP_PASS  = 5'b00011;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_SRL   = 5'b00101;
  localparam logic [4:0] OP_SRA   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_AND   = 5'b00111;
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULHU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_REM   = 5'b10100;
  localparam logic [4:0] OP_REMU  = 5'b10101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] o);
    return o[4] && (o[3:0] <= 4'd5);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative engine: shift-add multiply, restoring divide, one bit per cycle.
// Used by alu_mc only when ALU_MC_MULDIV_EN is defined.
module alu_mc_muldiv
  import alu_mc_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] dataa,
  input  logic [XLEN-1:0] datab,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt;
  logic            run;
  logic            k_mul;
  logic            k_hi;
  logic            k_rem;
  logic            neg_q;
  logic            neg_r;
  logic            bz;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] m;

  logic            s_mul;
  logic            s_sgn;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  assign s_mul = (op[2:1] == 2'b00);
  assign s_sgn = !s_mul && !op[0];
  assign sa    = s_sgn && dataa[XLEN-1];
  assign sb    = s_sgn && datab[XLEN-1];
  assign mag_a = sa ? -dataa : dataa;
  assign mag_b = sb ? -datab : datab;

  logic [XLEN:0]   sum;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] nhi;
  logic [XLEN-1:0] nlo;

  assign sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  assign trial = {hi, lo[XLEN-1]} - {1'b0, m};

  always_comb begin
    nhi = hi;
    nlo = lo;
    unique case (1'b1)
      k_mul: begin
        nhi = sum[XLEN:1];
        nlo = {sum[0], lo[XLEN-1:1]};
      end
      !k_mul && !trial[XLEN]: begin
        nhi = trial[XLEN-1:0];
        nlo = {lo[XLEN-2:0], 1'b1};
      end
      default: begin
        nhi = {hi[XLEN-2:0], lo[XLEN-1]};
        nlo = {lo[XLEN-2:0], 1'b0};
      end
    endcase
  end

  // Final answer is taken from the last step's next values so the
  // result is ready on the same edge the counter reaches zero.
  assign done = run && (cnt == CW'(1));

  always_comb begin
    result = '0;
    unique case (1'b1)
      k_mul:  result = k_hi ? nhi : nlo;
      k_rem:  result = neg_r ? -nhi : nhi;
      default: result = bz ? '1 : (neg_q ? -nlo : nlo);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      run   <= 1'b0;
      k_mul <= 1'b0;
      k_hi  <= 1'b0;
      k_rem <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bz    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
    end else if (start) begin
      cnt   <= CW'(XLEN);
      run   <= 1'b1;
      k_mul <= s_mul;
      k_hi  <= (op == 3'b001);
      k_rem <= op[2];
      neg_q <= sa ^ sb;
      neg_r <= sa;
      bz    <= (datab == '0);
      hi    <= '0;
      lo    <= s_mul ? datab : mag_a;
      m     <= s_mul ? dataa : mag_b;
    end else if (run) begin
      hi  <= nhi;
      lo  <= nlo;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on both sides.
// Define ALU_MC_MULDIV_EN to add the iterative mul/div/rem operations.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] dataa,
  input  logic [XLEN-1:0] datab,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less,
  output logic            err
);

  localparam int SW = $clog2(XLEN);

  state_t state;

  logic [SW-1:0] sh;
  logic          alt;
  logic          lt_s;
  logic          lt_u;

  assign sh   = datab[SW-1:0];
  assign alt  = op[3];
  assign lt_s = $signed(dataa) < $signed(datab);
  assign lt_u = dataa < datab;

  logic f_add, f_sll, f_slt, f_pass;
  logic f_xor, f_sr, f_or, f_and;

  assign f_add  = (op[2:0] == 3'b000);
  assign f_sll  = (op[2:0] == 3'b001);
  assign f_slt  = (op[2:0] == 3'b010);
  assign f_pass = (op[2:0] == 3'b011);
  assign f_xor  = (op[2:0] == 3'b100);
  assign f_sr   = (op[2:0] == 3'b101);
  assign f_or   = (op[2:0] == 3'b110);
  assign f_and  = (op[2:0] == 3'b111);

  logic signed [XLEN-1:0] sra_v;
  assign sra_v = $signed(dataa) >>> sh;

  logic [XLEN-1:0] alu_res;
  logic            alu_less;
  logic            alu_zero;

  always_comb begin
    alu_res  = '0;
    alu_less = 1'b0;
    unique case (1'b1)
      f_add:  alu_res = alt ? dataa - datab : dataa + datab;
      f_sll:  alu_res = dataa << sh;
      f_slt:  alu_less = alt ? lt_u : lt_s;
      f_pass: alu_res = datab;
      f_xor:  alu_res = dataa ^ datab;
      f_sr:   alu_res = alt ? sra_v : dataa >> sh;
      f_or:   alu_res = dataa | datab;
      f_and:  alu_res = dataa & datab;
      default: ;
    endcase
    if (f_slt) begin
      alu_res  = {{(XLEN-1){1'b0}}, alu_less};
      alu_zero = (dataa == datab);
    end else begin
      alu_zero = (alu_res == '0);
    end
  end

  logic md_op;
  logic illegal;

`ifdef ALU_MC_MULDIV_EN
  logic            md_done;
  logic [XLEN-1:0] md_result;

  assign md_op = is_muldiv(op);

  alu_mc_muldiv #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (in_valid && in_ready && md_op),
    .op     (op[2:0]),
    .dataa  (dataa),
    .datab  (datab),
    .done   (md_done),
    .result (md_result)
  );
`else
  assign md_op = 1'b0;
`endif

  assign illegal = op[4] && !md_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      less      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (md_op) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= illegal ? '0 : alu_res;
              zero      <= illegal || alu_zero;
              less      <= !illegal && alu_less;
              err       <= illegal;
            end
          end
        end
`ifdef ALU_MC_MULDIV_EN
        BUSY: begin
          if (md_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= md_result;
            zero      <= (md_result == '0);
            less      <= 1'b0;
            err       <= 1'b0;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (XLEN=32).
// Mul/div cases are selected when ALU_MC_MULDIV_EN is defined.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  op = 5'd0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        less;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        l;
  } vec_t;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dataa     (dataa),
    .datab     (datab),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .less      (less),
    .err       (err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    @(negedge clk);
    op = o; dataa = a; datab = b; in_valid = 1'b1;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
      dataa = $urandom;
      datab = $urandom;
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got=%b exp=1", in_ready); n_bad++;
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got=%b exp=0", out_valid); n_bad++;
    end
    n_cmp++;
    if ({result, zero, less, err} !== 35'd0) begin
      $display("FAIL reset_outputs got=%h %b%b%b exp=0 000",
               result, zero, less, err); n_bad++;
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    vec_t tv[14];
    int   lat;
    tv[0]  = {OP_ADD,  32'hFFFFFFFF, 32'h1,   32'h0,        1'b1, 1'b0};
    tv[1]  = {OP_SUB,  32'h5,        32'h7,   32'hFFFFFFFE, 1'b0, 1'b0};
    tv[2]  = {OP_SLT,  32'h80000000, 32'h1,   32'h1,        1'b0, 1'b1};
    tv[3]  = {OP_SLTU, 32'h80000000, 32'h1,   32'h0,        1'b0, 1'b0};
    tv[4]  = {OP_SLT,  32'h5,        32'h5,   32'h0,        1'b1, 1'b0};
    tv[5]  = {OP_SRA,  32'h80000000, 32'h4,   32'hF8000000, 1'b0, 1'b0};
    tv[6]  = {OP_SRL,  32'h80000000, 32'h4,   32'h08000000, 1'b0, 1'b0};
    tv[7]  = {5'b01001, 32'h1,       32'h25,  32'h20,       1'b0, 1'b0};
    tv[8]  = {OP_XOR,  32'hF0F0,     32'hFF00, 32'h0FF0,    1'b0, 1'b0};
    tv[9]  = {OP_OR,   32'hF0F0,     32'hFF00, 32'hFFF0,    1'b0, 1'b0};
    tv[10] = {OP_AND,  32'hF0F0,     32'hFF00, 32'hF000,    1'b0, 1'b0};
    tv[11] = {OP_PASS, 32'h1,        32'h0,   32'h0,        1'b1, 1'b0};
    tv[12] = {OP_SRA,  32'h7FFFFFF0, 32'h24,  32'h07FFFFFF, 1'b0, 1'b0};
    tv[13] = {OP_SLTU, 32'h1,        32'h80000000, 32'h1,   1'b0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      run_op(tv[i].o, tv[i].a, tv[i].b, lat);
      if (lat !== 1) begin
        $display("FAIL alu_latency[%0d] got=%0d exp=1", i, lat); n_bad++;
      end
      n_cmp++;
      if (result !== tv[i].r) begin
        $display("FAIL alu_result[%0d] got=%h exp=%h", i, result, tv[i].r);
        n_bad++;
      end
      n_cmp++;
      if ({zero, less, err} !== {tv[i].z, tv[i].l, 1'b0}) begin
        $display("FAIL alu_flags[%0d] zle got=%b%b%b exp=%b%b0",
                 i, zero, less, err, tv[i].z, tv[i].l); n_bad++;
      end
      n_cmp++;
      retire();
      if ({out_valid, in_ready} !== 2'b01) begin
        $display("FAIL alu_retire[%0d] vr got=%b%b exp=01",
                 i, out_valid, in_ready); n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_hold();
    int lat;
    run_op(OP_ADD, 32'd3, 32'd4, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op = OP_XOR;
      @(posedge clk);
      @(negedge clk);
      if ({out_valid, in_ready} !== 2'b10 || result !== 32'd7) begin
        $display("FAIL hold[%0d] vr=%b%b res=%h exp vr=10 res=00000007",
                 i, out_valid, in_ready, result); n_bad++;
      end
      n_cmp++;
    end
    in_valid = 1'b0;
    retire();
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL hold_retire vr got=%b%b exp=01", out_valid, in_ready);
      n_bad++;
    end
    n_cmp++;
  endtask

`ifdef ALU_MC_MULDIV_EN
  task automatic test_muldiv();
    vec_t tv[13];
    int   lat;
    tv[0]  = {OP_MUL,   32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b0, 1'b0};
    tv[1]  = {OP_MULHU, 32'hFFFFFFFF, 32'h2, 32'h1,        1'b0, 1'b0};
    tv[2]  = {OP_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b0, 1'b0};
    tv[3]  = {OP_REM,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1'b0, 1'b0};
    tv[4]  = {OP_DIVU,  32'h5,        32'h0, 32'hFFFFFFFF, 1'b0, 1'b0};
    tv[5]  = {OP_REMU,  32'h5,        32'h0, 32'h5,        1'b0, 1'b0};
    tv[6]  = {OP_DIV,   32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0};
    tv[7]  = {OP_REM,   32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 1'b0, 1'b0};
    tv[8]  = {OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0};
    tv[9]  = {OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0};
    tv[10] = {OP_MUL,   32'h0,        32'h1234, 32'h0,     1'b1, 1'b0};
    tv[11] = {OP_DIVU,  32'd100,      32'd7, 32'd14,       1'b0, 1'b0};
    tv[12] = {OP_REMU,  32'd100,      32'd7, 32'd2,        1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      run_op(tv[i].o, tv[i].a, tv[i].b, lat);
      if (lat !== 33) begin
        $display("FAIL md_latency[%0d] got=%0d exp=33", i, lat); n_bad++;
      end
      n_cmp++;
      if (result !== tv[i].r) begin
        $display("FAIL md_result[%0d] got=%h exp=%h", i, result, tv[i].r);
        n_bad++;
      end
      n_cmp++;
      if ({zero, less, err} !== {tv[i].z, 2'b00}) begin
        $display("FAIL md_flags[%0d] zle got=%b%b%b exp=%b00",
                 i, zero, less, err, tv[i].z); n_bad++;
      end
      n_cmp++;
      retire();
    end
  endtask
`endif

  task automatic test_illegal();
    logic [4:0] ops[3];
    int         lat;
`ifdef ALU_MC_MULDIV_EN
    ops[0] = 5'b10110; ops[1] = 5'b11000; ops[2] = 5'b11111;
`else
    ops[0] = 5'b10000; ops[1] = 5'b10101; ops[2] = 5'b11111;
`endif
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 32'h80000000, 32'h1, lat);
      if (lat !== 1) begin
        $display("FAIL ill_latency[%0d] got=%0d exp=1", i, lat); n_bad++;
      end
      n_cmp++;
      if ({result, zero, less, err} !== {32'h0, 3'b101}) begin
        $display("FAIL ill_out[%0d] got=%h %b%b%b exp=00000000 101",
                 i, result, zero, less, err); n_bad++;
      end
      n_cmp++;
      retire();
    end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
`ifdef ALU_MC_MULDIV_EN
    op = OP_MUL;
`else
    op = OP_ADD;
`endif
    dataa = 32'd9; datab = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    if (in_ready !== 1'b0) begin
      $display("FAIL abort_inflight in_ready got=%b exp=0", in_ready);
      n_bad++;
    end
    n_cmp++;
    rst_n = 1'b0;
    #1;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL abort_reset vr got=%b%b exp=01", out_valid, in_ready);
      n_bad++;
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    if (seen !== 0) begin
      $display("FAIL abort_no_result out_valid cycles got=%0d exp=0", seen);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op = OP_ADD; dataa = 32'd1; datab = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (result !== 32'd3 || out_valid !== 1'b1) begin
      $display("FAIL b2b_first res=%h v=%b exp res=00000003 v=1",
               result, out_valid); n_bad++;
    end
    n_cmp++;
    op = OP_XOR; dataa = 32'hA5A5A5A5; datab = 32'h0F0F0F0F;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL b2b_gap vr got=%b%b exp=01", out_valid, in_ready);
      n_bad++;
    end
    n_cmp++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (result !== 32'hAAAAAAAA || out_valid !== 1'b1) begin
      $display("FAIL b2b_second res=%h v=%b exp res=aaaaaaaa v=1",
               result, out_valid); n_bad++;
    end
    n_cmp++;
    retire();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_hold();
`ifdef ALU_MC_MULDIV_EN
    test_muldiv();
`endif
    test_illegal();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
